fault_injector: RTL and testbench

//  Register-file fault/access engine downstream of soc_control. Takes single commands (read, write,

---
 rtl/fault_injector.sv | 188 ++++++++++++++++++
 tb/tb_fault_injector.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_injector.sv
// Register-file fault/access engine: read, write, flip-now and flip-after-delay on the core's regfile.
// Latency: read responds HALT_SETTLE+2 cycles after accept, modify HALT_SETTLE+3, delayed flip adds `delay`.
// Backpressure: one command in flight; cmd_ready is low until the response has been taken via rsp_ready.
module fault_injector #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int HALT_SETTLE    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    input  logic [CNT_WIDTH-1:0]      cmd_delay,
    input  logic                      cancel,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_err,
    output logic                      armed,
    output logic                      cpu_stop,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      rf_we,
    input  logic [DATA_WIDTH-1:0]     rf_rdata
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DFLIP = 2'b11;

    // Settle counter only needs to reach HALT_SETTLE-1.
    localparam int SETTLE_W = (HALT_SETTLE > 1) ? $clog2(HALT_SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(HALT_SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HALT,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [1:0]                op_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [SETTLE_W-1:0]       settle_q;
    logic [DATA_WIDTH-1:0]     rsp_data_q;
    logic                      rsp_err_q;
    // Low while reset is held and for the first cycle after release, so
    // no command is ever accepted at an edge that still sees reset.
    logic                      run_q;

    logic                      accept;
    logic                      modify;
    logic                      addr_is_x0;

    assign accept     = cmd_valid && cmd_ready;
    assign modify     = (op_q != OP_READ);
    assign addr_is_x0 = (addr_q == '0);
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; all handshake and regfile strobes come straight from state.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        armed     = 1'b0;
        cpu_stop  = 1'b0;
        rsp_valid = 1'b0;
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        case (state)
            ST_IDLE: begin
                cmd_ready = run_q;
                if (cmd_valid && run_q) begin
                    if (cmd_op == OP_DFLIP && cmd_delay != '0) begin
                        state_nxt = ST_ARMED;
                    end else begin
                        state_nxt = ST_HALT;
                    end
                end
            end
            ST_ARMED: begin
                armed = 1'b1;
                // Cancel wins over expiry landing in the same cycle.
                if (cancel) begin
                    state_nxt = ST_RESP;
                end else if (cnt_q == CNT_WIDTH'(1)) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                cpu_stop = 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                cpu_stop = 1'b1;
                rf_addr  = addr_q;
                // x0 is hardwired; a modify aimed at it is refused without a write.
                if (!modify || addr_is_x0) begin
                    state_nxt = ST_RESP;
                end else begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cpu_stop  = 1'b1;
                rf_we     = 1'b1;
                rf_addr   = addr_q;
                rf_wdata  = (op_q == OP_WRITE) ? data_q : (rsp_data_q ^ data_q);
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command latch, delay/settle counters and the response register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q      <= 1'b0;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            settle_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                op_q       <= cmd_op;
                addr_q     <= cmd_addr;
                data_q     <= cmd_data;
                cnt_q      <= cmd_delay;
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end
            // Counter stops at zero because ARMED is left when it reads 1.
            if (state == ST_ARMED) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
                if (cancel) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end
            if (state == ST_HALT) begin
                settle_q <= settle_q + SETTLE_W'(1);
            end else begin
                settle_q <= '0;
            end
            // The pre-operation value is both the response and the XOR source.
            if (state == ST_READ) begin
                rsp_data_q <= rf_rdata;
                rsp_err_q  <= modify && addr_is_x0;
            end
        end
    end

endmodule

// File: tb/tb_fault_injector.sv
module tb_fault_injector;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;
    localparam int HS = 2;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [CW-1:0] cmd_delay;
    logic          cancel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          armed;
    logic          cpu_stop;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic          rf_we;
    logic [DW-1:0] rf_rdata;

    fault_injector #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW), .HALT_SETTLE(HS)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_delay(cmd_delay),
        .cancel(cancel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .armed(armed), .cpu_stop(cpu_stop),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        case (i)
            0:       return '0;
            3:       return 32'h3333_3333;
            5:       return 32'hDEAD_BEEF;
            7:       return 32'h0000_FFFF;
            12:      return 32'hCAFE_F00D;
            default: return (DW'(i) * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Regfile seen by the DUT: combinational read, x0 reads zero.
    logic [DW-1:0] rf [32];
    assign rf_rdata = (rf_addr == '0) ? '0 : rf[rf_addr];
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (rf_we && rf_addr != '0) rf[rf_addr] <= rf_wdata;
        end
    end

    // ---------------- behavioural model ----------------
    // One command in flight; timing is expressed as a cycle number n since the
    // accept edge (n=1 is the first cycle after it).
    logic [DW-1:0] shadow [32];
    int            cyc, acc, m_d, m_cancel;
    bit            busy, run, clean, started, m_wr, m_x0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_orig, m_wval;

    function automatic int rsp_start();
        return (m_cancel != 0) ? m_cancel + 1 : m_d + HS + 2 + int'(m_wr);
    endfunction

    initial begin
        int nn;
        for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
        cyc = 0; acc = 0; busy = 0; run = 0; clean = 1; started = 0;
        m_d = 0; m_cancel = 0; m_wr = 0; m_x0 = 0; m_addr = '0; m_orig = '0; m_wval = '0;
        forever begin
            @(posedge clk);
            nn = cyc - acc + 1;
            cyc++;
            if (rst !== 1'b1) begin
                busy = 0; run = 0; clean = 1; started = 1;
            end else if (started) begin
                if (busy) begin
                    if (m_cancel == 0 && cancel && nn >= 1 && nn <= m_d) m_cancel = nn;
                    if (nn >= rsp_start() && rsp_ready) begin
                        busy = 0;
                        if (m_wr && m_cancel == 0) shadow[m_addr] = m_wval;
                    end
                end else if (run && cmd_valid) begin
                    busy     = 1;
                    acc      = cyc;
                    clean    = 0;
                    m_addr   = cmd_addr;
                    m_d      = (cmd_op == 2'b11) ? int'(cmd_delay) : 0;
                    m_cancel = 0;
                    m_orig   = shadow[cmd_addr];
                    m_x0     = (cmd_op != 2'b00) && (cmd_addr == '0);
                    m_wr     = (cmd_op != 2'b00) && (cmd_addr != '0);
                    m_wval   = (cmd_op == 2'b01) ? cmd_data : (m_orig ^ cmd_data);
                end
                run = 1;
            end
        end
    end

    // Observations summarised per command for the hand-computed checks.
    int            obs_stop, obs_armed, obs_we, obs_rsp_n, obs_rsp_cnt;
    logic [DW-1:0] obs_wdata, obs_rdata;
    logic          obs_err;

    task automatic clear_obs();
        obs_stop = 0; obs_armed = 0; obs_we = 0; obs_rsp_n = 0; obs_rsp_cnt = 0;
        obs_wdata = '0; obs_rdata = '0; obs_err = 1'b0;
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    initial begin
        int n;
        bit e_armed, e_stop, e_we, e_rsp;
        forever begin
            @(negedge clk);
            if (started) begin
                n = cyc - acc + 1;
                e_armed = 0; e_stop = 0; e_we = 0; e_rsp = 0;
                if (busy) begin
                    e_armed = (n <= m_d) && (m_cancel == 0 || n <= m_cancel);
                    e_stop  = (m_cancel == 0) && (n > m_d) && (n <= m_d + HS + 1 + int'(m_wr));
                    e_we    = (m_cancel == 0) && m_wr && (n == m_d + HS + 2);
                    e_rsp   = (n >= rsp_start());
                end
                check("cmd_ready", 64'(cmd_ready), 64'(!busy && run));
                check("armed", 64'(armed), 64'(e_armed));
                check("cpu_stop", 64'(cpu_stop), 64'(e_stop));
                check("rf_we", 64'(rf_we), 64'(e_we));
                check("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
                if (e_rsp) begin
                    check("rsp_data", 64'(rsp_data), 64'((m_cancel != 0) ? '0 : m_orig));
                    check("rsp_err", 64'(rsp_err), 64'((m_cancel != 0) || m_x0));
                end
                if (busy && m_cancel == 0 && n == m_d + HS + 1) check("rf_addr_read", 64'(rf_addr), 64'(m_addr));
                if (e_we) begin
                    check("rf_addr_write", 64'(rf_addr), 64'(m_addr));
                    check("rf_wdata", 64'(rf_wdata), 64'(m_wval));
                end
                if (!busy && clean) begin
                    check("idle_rsp_data", 64'(rsp_data), 64'(0));
                    check("idle_rsp_err", 64'(rsp_err), 64'(0));
                    check("idle_rf_addr", 64'(rf_addr), 64'(0));
                    check("idle_rf_wdata", 64'(rf_wdata), 64'(0));
                end
                if (cpu_stop) obs_stop++;
                if (armed) obs_armed++;
                if (rf_we) begin obs_we++; obs_wdata = rf_wdata; end
                if (rsp_valid) begin
                    if (obs_rsp_n == 0) obs_rsp_n = n;
                    obs_rsp_cnt++;
                    obs_rdata = rsp_data;
                    obs_err   = rsp_err;
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || !run) && k < 300) begin @(negedge clk); #1; k++; end
        check("idle_wait_timeout", 64'(busy || !run), 64'(0));
    endtask

    // Issue one command and carry it through to its response handshake.
    task automatic run_cmd(input logic [1:0] op, input int addr, input logic [DW-1:0] data,
                           input int delay, input int cancel_at, input int hold);
        int k, rs;
        wait_idle();
        clear_obs();
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = AW'(addr); cmd_data = data; cmd_delay = CW'(delay);
        @(negedge clk); #1;
        k = 1;
        while (busy && k < 600) begin
            cancel    = (k == cancel_at) || (k > m_d && $urandom_range(0, 3) == 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_data  = $urandom;
            cmd_delay = CW'($urandom);
            rs = rsp_start();
            if (k >= rs + hold)  rsp_ready = 1'b1;
            else if (k >= rs)    rsp_ready = 1'b0;
            else                 rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            k++;
        end
        check("rsp_timeout", 64'(busy), 64'(0));
        cmd_valid = 1'b0; cancel = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int op, addr, dly, cat;
        rst = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'd4; cmd_data = 32'h1111_2222;
        cmd_delay = '0; cancel = 1'b0; rsp_ready = 1'b0;

        // Reset held 3 edges with a command offered: nothing accepted.
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        #1; rst = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        check("release_cmd_ready", 64'(cmd_ready), 64'(1));
        #1;

        // Read x5.
        run_cmd(2'b00, 5, 32'h0, 0, 0, 0);
        check("read_stop_cycles", 64'(obs_stop), 64'(3));
        check("read_rsp_cycle", 64'(obs_rsp_n), 64'(4));
        check("read_data", 64'(obs_rdata), 64'(32'hDEAD_BEEF));
        check("read_no_we", 64'(obs_we), 64'(0));

        // Flip-now x7.
        run_cmd(2'b10, 7, 32'h0001_0001, 0, 0, 0);
        check("flip_we_pulses", 64'(obs_we), 64'(1));
        check("flip_wdata", 64'(obs_wdata), 64'(32'h0001_FFFE));
        check("flip_rsp_data", 64'(obs_rdata), 64'(32'h0000_FFFF));
        check("flip_rsp_err", 64'(obs_err), 64'(0));
        check("flip_rsp_cycle", 64'(obs_rsp_n), 64'(5));
        run_cmd(2'b00, 7, 32'h0, 0, 0, 0);
        check("flip_readback", 64'(obs_rdata), 64'(32'h0001_FFFE));

        // Write x0 refused.
        run_cmd(2'b01, 0, 32'h1234_5678, 0, 0, 0);
        check("x0_err", 64'(obs_err), 64'(1));
        check("x0_data", 64'(obs_rdata), 64'(0));
        check("x0_no_we", 64'(obs_we), 64'(0));
        check("x0_stop_cycles", 64'(obs_stop), 64'(3));

        // Delayed flip, delay 10, then the same cancelled at cycle 4.
        run_cmd(2'b11, 9, 32'h8000_0001, 10, 0, 0);
        check("dflip_armed_cycles", 64'(obs_armed), 64'(10));
        check("dflip_stop_cycles", 64'(obs_stop), 64'(4));
        check("dflip_rsp_cycle", 64'(obs_rsp_n), 64'(15));
        run_cmd(2'b11, 9, 32'h8000_0001, 10, 4, 0);
        check("cancel_err", 64'(obs_err), 64'(1));
        check("cancel_data", 64'(obs_rdata), 64'(0));
        check("cancel_stop", 64'(obs_stop), 64'(0));
        check("cancel_armed_cycles", 64'(obs_armed), 64'(4));
        check("cancel_no_we", 64'(obs_we), 64'(0));

        // Delay 0 behaves like flip-now; mask 0 writes the value back.
        run_cmd(2'b11, 11, 32'h0000_0001, 0, 0, 0);
        check("delay0_armed", 64'(obs_armed), 64'(0));
        check("delay0_rsp_cycle", 64'(obs_rsp_n), 64'(5));
        run_cmd(2'b10, 12, 32'h0, 0, 0, 0);
        check("mask0_wdata", 64'(obs_wdata), 64'(32'hCAFE_F00D));

        // Maximum delay for an 8-bit counter runs to zero and exits.
        run_cmd(2'b11, 13, 32'hFFFF_FFFF, 255, 0, 0);
        check("maxdelay_armed", 64'(obs_armed), 64'(255));
        check("maxdelay_rsp_cycle", 64'(obs_rsp_n), 64'(260));

        // Response held off for 5 cycles.
        run_cmd(2'b00, 5, 32'h0, 0, 0, 5);
        check("hold_rsp_cycles", 64'(obs_rsp_cnt), 64'(6));

        // Reset during a write's HALT: no write, no response.
        wait_idle();
        clear_obs();
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'd3; cmd_data = 32'hA5A5_5A5A; cmd_delay = '0;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rstmid_no_we", 64'(obs_we), 64'(0));
        check("rstmid_stop_cycles", 64'(obs_stop), 64'(1));
        check("rstmid_no_rsp", 64'(obs_rsp_cnt), 64'(0));
        run_cmd(2'b00, 3, 32'h0, 0, 0, 0);
        check("rstmid_x3_intact", 64'(obs_rdata), 64'(32'h3333_3333));

        // Randomised commands against the model.
        for (int t = 0; t < 40; t++) begin
            op   = $urandom_range(0, 3);
            addr = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
            dly  = $urandom_range(0, 12);
            cat  = (op == 3 && dly > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, dly) : 0;
            run_cmd(2'(op), addr, $urandom, dly, cat, $urandom_range(0, 3));
        end

        wait_idle();
        for (int i = 0; i < 32; i++) check("rf_final", 64'(rf[i]), 64'(shadow[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
